// File: rtl/int_mul_pkg.sv
// Shared definitions for the sequential RISC-V M-extension multiplier:
// op encodings, FSM state type and operand signedness helpers.
package int_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  function automatic logic op_rs1_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_rs2_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/int_mul_pp_row.sv
// One multiplier iteration: folds RADIX_BITS shifted partial products into the
// double-width accumulator through a carry-save row and a final adder.
module int_mul_pp_row #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic [2*WIDTH-1:0]         acc,
  input  logic [2*WIDTH-1:0]         mcand,
  input  logic [RADIX_BITS-1:0]      mplier_bits,
  input  logic [$clog2(WIDTH)-1:0]   bit_offset,
  input  logic                       neg_top,
  output logic [2*WIDTH-1:0]         acc_next
);

  localparam int DW = 2 * WIDTH;

  logic [DW-1:0] sum;
  logic [DW-1:0] carry;
  logic [DW-1:0] sum_n;
  logic [DW-1:0] term;

  // The sign-weighted top bit is subtracted as ~pp + 1; the +1 enters as the
  // carry-in of the final adder so the row itself stays a plain 3:2 chain.
  always_comb begin
    sum   = acc;
    carry = '0;
    sum_n = '0;
    term  = '0;
    for (int k = 0; k < RADIX_BITS; k++) begin
      term = mplier_bits[k] ? (mcand << (int'(bit_offset) + k)) : '0;
      if (neg_top && (k == RADIX_BITS - 1)) term = ~term;
      sum_n = sum ^ carry ^ term;
      carry = ((sum & carry) | (sum & term) | (carry & term)) << 1;
      sum   = sum_n;
    end
    acc_next = sum + carry + DW'(neg_top);
  end

endmodule

// File: rtl/int_mul_seq.sv
// Multi-cycle integer multiplier for MUL/MULH/MULHSU/MULHU with valid/ready
// handshakes, a pass-through tag and flush; retires RADIX_BITS bits per cycle.
module int_mul_seq
  import int_mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int OFF_W = $clog2(WIDTH);

  mul_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [OFF_W-1:0]   bit_pos;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg_top;

  // Only the final iteration carries rs2's sign bit, which has negative weight.
  assign neg_top = op_rs2_signed(op_q) && (count == CNT_W'(1));

  int_mul_pp_row #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp_row (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier_bits (mplier_q[bit_pos +: RADIX_BITS]),
    .bit_offset  (bit_pos),
    .neg_top     (neg_top),
    .acc_next    (acc_next)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= MUL_IDLE;
      count       <= '0;
      bit_pos     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      op_q        <= MUL_OP_MUL;
      acc_q       <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      tag_o       <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (in_valid_i && !flush_i) begin
            state      <= MUL_BUSY;
            count      <= CNT_W'(N);
            bit_pos    <= '0;
            mcand_q    <= {{WIDTH{op_rs1_signed(op_i) & rs1_i[WIDTH-1]}}, rs1_i};
            mplier_q   <= rs2_i;
            op_q       <= op_i;
            acc_q      <= '0;
            tag_o      <= tag_i;
            in_ready_o <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (flush_i) begin
            state      <= MUL_IDLE;
            in_ready_o <= 1'b1;
          end else begin
            acc_q   <= acc_next;
            count   <= count - CNT_W'(1);
            bit_pos <= bit_pos + OFF_W'(RADIX_BITS);
            if (count == CNT_W'(1)) begin
              state       <= MUL_DONE;
              out_valid_o <= 1'b1;
              result_o    <= (op_q == MUL_OP_MUL) ? acc_next[WIDTH-1:0]
                                                  : acc_next[2*WIDTH-1:WIDTH];
            end
          end
        end
        MUL_DONE: begin
          if (flush_i || out_ready_i) begin
            state       <= MUL_IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: begin
          state       <= MUL_IDLE;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_mul_seq.sv
// Self-checking bench for int_mul_seq: directed corner cases, backpressure,
// flush and reset, then randomized ops against a plain-arithmetic model.
module tb_int_mul_seq;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  tag_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  int_mul_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .tag_i       (tag_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .tag_o       (tag_o)
  );

  // Reference: extend both operands to 64 bits by the op's signedness and multiply.
  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               input logic [31:0] expected, input int stall,
                               input bit flush_done);
    int k;
    @(negedge clk_i);
    checkOutput("in_ready_idle", in_ready_o, 1);
    in_valid_i = 1'b1;
    op_i = op; rs1_i = a; rs2_i = b; tag_i = tag;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    k = 0;
    while (!out_valid_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("latency", k, 16);
    checkOutput("result", result_o, expected);
    checkOutput("tag", tag_o, tag);
    for (int s = 0; s < stall; s++) begin
      in_valid_i = 1'b1;
      op_i = 2'($urandom_range(0, 3)); rs1_i = $urandom; rs2_i = $urandom;
      tag_i = 5'($urandom);
      @(negedge clk_i);
      checkOutput("stall_valid", out_valid_o, 1);
      checkOutput("stall_result", result_o, expected);
      checkOutput("stall_tag", tag_o, tag);
      checkOutput("stall_ready", in_ready_o, 0);
    end
    in_valid_i = 1'b0;
    if (flush_done) flush_i = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    flush_i = 1'b0;
    checkOutput("valid_drop", out_valid_o, 0);
    checkOutput("ready_back", in_ready_o, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    bit          stale;
    rst_ni = 1'b0; in_valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    tag_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_in_ready", in_ready_o, 1);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_tag", tag_o, 0);
    rst_ni = 1'b1;

    applyStimulus(OP_MUL,    32'hFFFF_FFFD, 32'd7,        5'h03, 32'hFFFF_FFEB, 0, 1'b0);
    applyStimulus(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'h04, 32'h4000_0000, 0, 1'b0);
    applyStimulus(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, 32'hFFFF_FFFE, 0, 1'b0);
    applyStimulus(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1A, 32'h0000_0000, 0, 1'b0);
    applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1A, 32'hFFFF_FFFF, 10, 1'b0);

    // Reset mid-BUSY must return every output to its reset value.
    @(negedge clk_i);
    in_valid_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd1234; rs2_i = 32'd99; tag_i = 5'h11;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (6) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    checkOutput("midrst_in_ready", in_ready_o, 1);
    checkOutput("midrst_out_valid", out_valid_o, 0);
    checkOutput("midrst_result", result_o, 0);
    checkOutput("midrst_tag", tag_o, 0);
    stale = 1'b0;
    repeat (18) begin
      @(negedge clk_i);
      if (out_valid_o) stale = 1'b1;
    end
    checkOutput("midrst_stale", stale, 0);

    // Flush in BUSY, then a fresh MULHU must not see the aborted result.
    @(negedge clk_i);
    in_valid_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd123; rs2_i = 32'd456; tag_i = 5'h07;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("flush_out_valid", out_valid_o, 0);
    checkOutput("flush_in_ready", in_ready_o, 1);
    stale = 1'b0;
    repeat (18) begin
      @(negedge clk_i);
      if (out_valid_o || !in_ready_o) stale = 1'b1;
    end
    checkOutput("flush_stale", stale, 0);
    applyStimulus(OP_MULHU, 32'd3, 32'd5, 5'h09, 32'h0000_0000, 0, 1'b0);
    applyStimulus(OP_MUL,   32'd3, 32'd5, 5'h0A, 32'd15, 2, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
        3: a = 32'd0;
        default: ;
      endcase
      applyStimulus(op, a, b, 5'($urandom), refMul(op, a, b),
                    $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
